// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer downstream of the per-domain reset synchronizers.
// Holds NUM_DOM reset outputs asserted until the clock source locks. It then
// releases them one by one, lowest index first, with STAGE_DLY cycles between
// releases. It serves a software soft-reset req/ack handshake, and it
// re-sequences on lock loss.
// Optional feature macro: RST_SEQ_LOCK_TO_EN (WAIT_LOCK timeout with sticky lock_err).
module rst_seq_ctrl #(
  parameter int NUM_DOM   = 4,
  parameter int CNT_W     = 10,
  parameter int HOLD_CYC  = 8,
  parameter int STAGE_DLY = 16,
  parameter int LOCK_TO   = 1000
) (
  input  logic               clk,
  input  logic               irst,
  input  logic               lock_i,
  input  logic               sw_req,
  output logic               sw_ack,
  output logic [NUM_DOM-1:0] orst,
  output logic               done,
  output logic               busy,
  output logic               lock_err,
  output logic [1:0]         state_o
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOM - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
`ifdef RST_SEQ_LOCK_TO_EN
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TO - 1);
`endif

  // Reject parameter sets that the counter or the output bank cannot represent.
  if (NUM_DOM < 1 || NUM_DOM > 16) begin : g_bad_num_dom
    $error("rst_seq_ctrl: NUM_DOM must be 1..16");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > (2**CNT_W) - 1) begin : g_bad_hold
    $error("rst_seq_ctrl: HOLD_CYC does not fit in CNT_W");
  end
  if (STAGE_DLY < 1 || STAGE_DLY > (2**CNT_W) - 1) begin : g_bad_stage
    $error("rst_seq_ctrl: STAGE_DLY does not fit in CNT_W");
  end
  if (LOCK_TO < 1 || LOCK_TO > (2**CNT_W) - 1) begin : g_bad_lock_to
    $error("rst_seq_ctrl: LOCK_TO does not fit in CNT_W");
  end

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_REL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] orst_q, orst_d;
  logic               pend_q, pend_d;
  logic               hold_off_q, hold_off_d;  // blocks re-arm until sw_req drops after an ack
  logic               ack_q, ack_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               restart;
  logic               accept;
`ifdef RST_SEQ_LOCK_TO_EN
  logic               err_q, err_d;
`endif

  // A request is taken once per handshake: not while one is pending, not in the
  // ack cycle, and not again until the requester has dropped sw_req.
  assign accept = sw_req && !pend_q && !ack_q && !hold_off_q;

  // Next-state, counter, release bank and handshake bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    orst_d     = orst_q;
    pend_d     = pend_q;
    hold_off_d = hold_off_q;
    ack_d      = 1'b0;
    restart    = 1'b0;
`ifdef RST_SEQ_LOCK_TO_EN
    err_d      = err_q;
`endif
    if (accept) pend_d = 1'b1;

    case (state_q)
      S_HOLD: begin
        orst_d = '1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        orst_d = '1;
        if (lock_i) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_REL;
        end
`ifdef RST_SEQ_LOCK_TO_EN
        else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_REL: begin
        if (!lock_i) begin
          restart = 1'b1;
        end else if (cnt_q == STAGE_LAST) begin
          orst_d[idx_q] = 1'b0;
          cnt_d         = '0;
          idx_d         = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_DONE;
            // A request taken during this sequence is satisfied by its completion.
            if (pend_q || accept) begin
              ack_d  = 1'b1;
              pend_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        orst_d = '0;
        if (!lock_i || accept) restart = 1'b1;
      end
      default: restart = 1'b1;
    endcase

    if (restart) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      orst_d  = '1;
    end

    if (ack_d)        hold_off_d = 1'b1;
    else if (!sw_req) hold_off_d = 1'b0;

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_DONE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (irst) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      orst_q     <= '1;
      pend_q     <= 1'b0;
      hold_off_q <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
`ifdef RST_SEQ_LOCK_TO_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      orst_q     <= orst_d;
      pend_q     <= pend_d;
      hold_off_q <= hold_off_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef RST_SEQ_LOCK_TO_EN
      err_q      <= err_d;
`endif
    end
  end

  assign sw_ack  = ack_q;
  assign orst    = orst_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign state_o = state_q;
`ifdef RST_SEQ_LOCK_TO_EN
  assign lock_err = err_q;
`else
  assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus randomized lock/sw_req/irst
// traffic, checked every cycle against an elapsed-time reference model.
module tb_rst_seq_ctrl;
  localparam int NUM_DOM   = 4;
  localparam int CNT_W     = 10;
  localparam int HOLD_CYC  = 8;
  localparam int STAGE_DLY = 16;
  localparam int LOCK_TO   = 20;
`ifdef RST_SEQ_LOCK_TO_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               irst, lock_i, sw_req;
  logic               sw_ack, done, busy, lock_err;
  logic [NUM_DOM-1:0] orst;
  logic [1:0]         state_o;

  rst_seq_ctrl #(
    .NUM_DOM(NUM_DOM), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC),
    .STAGE_DLY(STAGE_DLY), .LOCK_TO(LOCK_TO)
  ) dut (
    .clk(clk), .irst(irst), .lock_i(lock_i), .sw_req(sw_req),
    .sw_ack(sw_ack), .orst(orst), .done(done), .busy(busy),
    .lock_err(lock_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: phase (0 HOLD, 1 WAIT_LOCK, 2 REL, 3 DONE) and cycles spent in it.
  int m_ph, m_t;
  bit m_pend, m_blk, m_ack, m_err;

  task automatic model_step();
    bit acc, nack;
    if (irst) begin
      m_ph = 0; m_t = 0; m_pend = 0; m_blk = 0; m_ack = 0; m_err = 0;
    end else begin
      acc  = sw_req && !m_pend && !m_ack && !m_blk;
      nack = 0;
      case (m_ph)
        0: begin
          m_t++;
          if (m_t == HOLD_CYC) begin m_ph = 1; m_t = 0; end
        end
        1: begin
          if (lock_i) begin
            m_ph = 2; m_t = 0;
          end else if (LOCK_EN) begin
            m_t++;
            if (m_t == LOCK_TO) begin m_err = 1; m_ph = 0; m_t = 0; end
          end
        end
        2: begin
          if (!lock_i) begin
            m_ph = 0; m_t = 0;
          end else begin
            m_t++;
            if (m_t == NUM_DOM * STAGE_DLY) begin
              m_ph = 3; m_t = 0;
              if (m_pend || acc) nack = 1;
            end
          end
        end
        default: begin
          if (!lock_i || acc) begin m_ph = 0; m_t = 0; end
        end
      endcase
      if (acc) m_pend = 1;
      if (nack) m_pend = 0;
      if (nack) m_blk = 1;
      else if (!sw_req) m_blk = 0;
      m_ack = nack;
    end
  endtask

  function automatic logic [NUM_DOM-1:0] exp_orst();
    logic [NUM_DOM-1:0] r;
    r = '1;
    if (m_ph == 3) r = '0;
    else if (m_ph == 2)
      for (int k = 0; k < NUM_DOM; k++) r[k] = (m_t < (k + 1) * STAGE_DLY);
    return r;
  endfunction

  task automatic compare_all();
    chk("orst", orst, exp_orst());
    chk("state", state_o, m_ph);
    chk("done", done, m_ph == 3);
    chk("busy", busy, m_ph != 3);
    chk("sw_ack", sw_ack, m_ack);
    chk("lock_err", lock_err, m_err);
  endtask

  // One clock edge: model follows the inputs the DUT sampled, outputs checked 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    cyc++;
  endtask

  task automatic do_reset(input int n);
    irst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    irst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_orst(input logic [NUM_DOM-1:0] v, input string tag);
    for (int i = 0; i < 200 && orst != v; i++) tick();
    chk(tag, orst, v);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && !done; i++) tick();
    chk(tag, done, 1);
  endtask

  initial begin
    int fall[NUM_DOM];
    int exp_fall[NUM_DOM];
    int done_cyc, acks, st8, st9, rel_cyc, early_bad, holds, err_cyc, st_err, notdone;
    bit acked;
    exp_fall = '{25, 41, 57, 73};

    irst = 1'b1; lock_i = 1'b1; sw_req = 1'b0;
    do_reset(3);
    chk("rst_orst", orst, 4'hF);
    chk("rst_busy", busy, 1);
    chk("rst_state", state_o, 0);

    // Power-up sequence with lock constantly high.
    for (int k = 0; k < NUM_DOM; k++) fall[k] = 0;
    done_cyc = 0; acks = 0; st8 = -1; st9 = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      for (int k = 0; k < NUM_DOM; k++) if (fall[k] == 0 && orst[k] == 1'b0) fall[k] = cyc;
      if (done_cyc == 0 && done) done_cyc = cyc;
      if (sw_ack) acks++;
      if (cyc == 8) st8 = state_o;
      if (cyc == 9) st9 = state_o;
    end
    for (int k = 0; k < NUM_DOM; k++) chk($sformatf("fall_cyc%0d", k), fall[k], exp_fall[k]);
    chk("done_cyc", done_cyc, 73);
    chk("no_ack", acks, 0);
    chk("cyc8_wait", st8, 1);
    chk("cyc9_rel", st9, 2);

    // Soft reset from DONE, then holding sw_req high must not restart.
    sw_req = 1'b1;
    tick();
    chk("sw_restart_orst", orst, 4'hF);
    chk("sw_restart_busy", busy, 1);
    for (int i = 0; i < 200 && !sw_ack; i++) tick();
    chk("sw_ack_seen", sw_ack, 1);
    chk("ack_with_done", done, 1);
    acks = 0; notdone = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sw_ack) acks++;
      if (!done) notdone++;
    end
    chk("held_req_acks", acks, 0);
    chk("held_req_notdone", notdone, 0);
    sw_req = 1'b0;
    tick();

    // Lock arrives late: sampled high first at edge 30.
    lock_i = 1'b0;
    do_reset(3);
    rel_cyc = 0; fall[0] = 0; early_bad = 0;
    for (int i = 0; i < 60; i++) begin
      lock_i = (cyc >= 30);
      tick();
      if (rel_cyc == 0 && state_o == 2'd2) rel_cyc = cyc;
      if (fall[0] == 0 && orst[0] == 1'b0) fall[0] = cyc;
      if (cyc < 47 && orst != 4'hF) early_bad++;
    end
    chk("late_rel_cyc", rel_cyc, 31);
    chk("late_fall0", fall[0], 47);
    chk("late_early_release", early_bad, 0);

    // Request mid-REL after orst[1] released: no restart, ack at DONE entry.
    lock_i = 1'b1;
    do_reset(2);
    wait_orst(4'hC, "midrel_reach");
    sw_req = 1'b1;
    holds = 0;
    for (int i = 0; i < 200 && !sw_ack; i++) begin
      tick();
      if (state_o == 2'd0) holds++;
    end
    chk("midrel_ack", sw_ack, 1);
    chk("midrel_ack_done", done, 1);
    chk("midrel_no_restart", holds, 0);
    sw_req = 1'b0;
    tick();

    // One-cycle lock drop in REL and in DONE.
    do_reset(2);
    wait_orst(4'hC, "drop_reach");
    lock_i = 1'b0;
    tick();
    chk("drop_rel_orst", orst, 4'hF);
    chk("drop_rel_state", state_o, 0);
    lock_i = 1'b1;
    wait_done("drop_rel_redone");
    lock_i = 1'b0;
    tick();
    chk("drop_done_orst", orst, 4'hF);
    chk("drop_done_state", state_o, 0);
    lock_i = 1'b1;
    wait_done("drop_done_redone");

    // Lock never arrives: timeout behaviour (only with the optional feature).
    lock_i = 1'b0;
    do_reset(2);
    err_cyc = 0; st_err = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (err_cyc == 0 && lock_err) begin err_cyc = cyc; st_err = state_o; end
    end
    chk("lockerr_cyc", err_cyc, LOCK_EN ? 28 : 0);
    chk("lockerr_state", st_err, LOCK_EN ? 0 : -1);
    chk("lockerr_final", lock_err, LOCK_EN);
    do_reset(1);
    chk("lockerr_cleared", lock_err, 0);

    // Randomized traffic.
    lock_i = 1'b1;
    acked = 0;
    for (int i = 0; i < 3000; i++) begin
      lock_i = ($urandom_range(0, 99) != 0);
      irst = ($urandom_range(0, 599) == 0);
      if (sw_ack) acked = 1;
      if (acked && $urandom_range(0, 3) == 0) begin
        sw_req = 1'b0; acked = 0;
      end else if (!sw_req && $urandom_range(0, 30) == 0) begin
        sw_req = 1'b1;
      end else if (sw_req && $urandom_range(0, 199) == 0) begin
        sw_req = 1'b0;
      end
      tick();
    end
    irst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer/controller sitting downstream of the per-domain reset synchronizers. It holds a bank of NUM_DOM reset outputs asserted until the clock source reports lock. It then releases them one at a time, lowest index first, with a programmable spacing. It also serves a software soft-reset request through a req/ack handshake, and re-sequences automatically when lock is lost.

Parameters:
NUM_DOM, 4, number of sequenced reset outputs (1..16)
CNT_W, 10, width of the shared delay counter
HOLD_CYC, 8, minimum cycles all resets are held asserted in HOLD (1..2^CNT_W-1)
STAGE_DLY, 16, cycles between successive releases in REL (1..2^CNT_W-1)
LOCK_TO, 1000, WAIT_LOCK timeout in cycles (used only with optional feature)

Ports:
clk  in  1  system clock
irst  in  1  reset: synchronous, active-high, sampled on rising clk
lock_i  in  1  clock-source lock, already synchronized to clk
sw_req  in  1  soft-reset request, level; hold high until sw_ack
sw_ack  out  1  one-cycle pulse: requested sequence has completed
orst  out  NUM_DOM  per-domain reset outputs, active-high, registered
done  out  1  high only in DONE state
busy  out  1  high in any state other than DONE
lock_err  out  1  sticky lock-timeout flag (optional feature)
state_o  out  2  current state: 0 HOLD, 1 WAIT_LOCK, 2 REL, 3 DONE

Behaviour:
- Reset (irst=1 at a clk edge):
  - state=HOLD, counter cnt=0, stage index idx=0, pend=0.
  - orst=all 1, done=0, busy=1, sw_ack=0, lock_err=0.
- All outputs are registered; no combinational path from any input to any output.
- Cycle numbering: cycle 0 is the first edge with irst=0.
- HOLD:
  - orst all 1; cnt increments each cycle.
  - When cnt==HOLD_CYC-1: cnt:=0, go to WAIT_LOCK.
- WAIT_LOCK:
  - orst all 1.
  - lock_i=1 sampled: cnt:=0, idx:=0, go to REL. This takes one cycle minimum.
- REL:
  - cnt increments each cycle.
  - When cnt==STAGE_DLY-1: orst[idx] cleared on that edge, cnt:=0, idx:=idx+1.
  - When idx==NUM_DOM-1 is released: go to DONE on the same edge.
  - orst[k] falls exactly (k+1)*STAGE_DLY cycles after REL entry; already-released bits stay 0.
- DONE:
  - orst all 0, done=1, busy=0.
- Lock loss (lock_i=0 in REL or DONE):
  - Next edge: state=HOLD, orst all 1, cnt:=0, idx:=0.
  - pend is unchanged.
- sw_req rising (level high while pend=0 and sw_ack=0):
  - In DONE: go to HOLD (as lock loss) and set pend:=1.
  - In HOLD, WAIT_LOCK or REL: set pend:=1 only; the sequence in progress is not restarted.
- sw_ack:
  - Pulses for the single cycle in which state enters DONE with pend=1; pend is cleared on that edge.
  - While sw_req remains high after sw_ack, no new request is registered; the requester must drop sw_req for at least one cycle.
- Simultaneous lock loss and sw_req in DONE: go to HOLD with pend:=1; sw_ack is issued at the next DONE entry.
- irst mid-sequence: full reset as above, including pend:=0; no sw_ack is issued for the aborted request.
- Counter widths: cnt is CNT_W bits. HOLD_CYC, STAGE_DLY and LOCK_TO must fit in CNT_W; elaboration fails via a generate-time check otherwise.

Optional Feature:
Macro RST_SEQ_LOCK_TO_EN.
- Defined:
  - In WAIT_LOCK, cnt counts cycles without lock.
  - When cnt==LOCK_TO-1 with lock_i=0: lock_err:=1 (sticky until irst), cnt:=0, return to HOLD and retry indefinitely.
  - lock_err does not affect orst.
- Not defined:
  - WAIT_LOCK waits forever.
  - lock_err is tied to 0; LOCK_TO is unused.

Test Plan:
- Defaults, lock_i=1 constant, irst pulsed for 3 cycles:
  - Cycles 0..7 HOLD; cycle 8 WAIT_LOCK; cycle 9 REL entry.
  - orst[0..3] fall at cycles 25/41/57/73; done=1 from 73; sw_ack never pulses.
- lock_i=0 until cycle 30, then 1:
  - Stay in WAIT_LOCK until cycle 30, REL from 31.
  - orst[0] falls at 47; orst stays 0xF before 47.
- In DONE, assert sw_req:
  - orst=0xF and busy=1 on the next cycle; full sequence repeats.
  - sw_ack is a single-cycle pulse coincident with done rising; holding sw_req high afterwards causes no restart.
- sw_req asserted mid-REL (after orst[1] released):
  - Sequence continues uninterrupted to DONE; sw_ack pulses at DONE entry.
- lock_i dropped for 1 cycle when orst=0xC (in REL):
  - Next cycle orst=0xF, state=HOLD; full resequence completes.
  - A drop in DONE gives the same result.
- RST_SEQ_LOCK_TO_EN defined, LOCK_TO=20, lock_i=0:
  - WAIT_LOCK entered at cycle 8; lock_err rises at cycle 28, then state=HOLD.
  - HOLD/WAIT cycle repeats; lock_err stays 1 until irst.
  - Without the macro, lock_err=0 throughout.
